// File: rtl/adv7180_cfg_pkg.sv
// adv7180_cfg_pkg
//   Shared constants for the ADV7180 init sequencer: I2C master core
//   register offsets, CR/SR bit positions and the sequencer state encoding.
package adv7180_cfg_pkg;

    // I2C master core Wishbone register map (CR and SR share offset 4)
    localparam logic [2:0] REG_PRER_LO = 3'd0;
    localparam logic [2:0] REG_PRER_HI = 3'd1;
    localparam logic [2:0] REG_CTR     = 3'd2;
    localparam logic [2:0] REG_TXR     = 3'd3;
    localparam logic [2:0] REG_CR      = 3'd4;
    localparam logic [2:0] REG_SR      = 3'd4;

    localparam logic [7:0] CTR_EN = 8'h80;

    // CR command bits
    localparam logic [7:0] CR_STA = 8'h80;
    localparam logic [7:0] CR_STO = 8'h40;
    localparam logic [7:0] CR_WR  = 8'h10;

    // SR bit positions
    localparam int SR_RXACK = 7;
    localparam int SR_AL    = 5;
    localparam int SR_TIP   = 1;

    // Number of table entries held in adv7180_init_rom
    localparam int ROM_LEN = 16;

    typedef enum logic [3:0] {
        S_WAIT_PWR,
        S_PRE_LO,
        S_PRE_HI,
        S_CTR_EN,
        S_LD_DEV,
        S_LD_REG,
        S_LD_DAT,
        S_CMD,
        S_POLL,
        S_NEXT,
        S_FAIL,
        S_DONE,
        S_ERROR
    } state_t;

    // Which byte of the 3-byte write is in flight
    typedef enum logic [1:0] {
        PH_DEV,
        PH_REG,
        PH_DAT
    } phase_t;

endpackage

// File: rtl/adv7180_init_rom.sv
// adv7180_init_rom
//   Combinational power-up register table for the ADV7180 decoder.
//   Ports:
//     index   in  8  table entry
//     rom_reg out 8  decoder register address
//     rom_val out 8  value to write
//   Indices past the table return 0.
module adv7180_init_rom (
    input  logic [7:0] index,
    output logic [7:0] rom_reg,
    output logic [7:0] rom_val
);
    import adv7180_cfg_pkg::*;

    logic [15:0] entry;

    always_comb begin
        entry = 16'h0000;
        case (index)
            8'd0:  entry = {8'h0F, 8'h00};  // leave power-down
            8'd1:  entry = {8'h00, 8'h04};  // input control: autodetect
            8'd2:  entry = {8'h04, 8'h57};  // extended output control
            8'd3:  entry = {8'h17, 8'h41};  // shaping filter
            8'd4:  entry = {8'h31, 8'h02};  // VS/FIELD control
            8'd5:  entry = {8'h3D, 8'hA2};  // manual window
            8'd6:  entry = {8'h3E, 8'h6A};  // BLM optimisation
            8'd7:  entry = {8'h3F, 8'hA0};  // BGB optimisation
            8'd8:  entry = {8'h0E, 8'h80};  // enter user sub-map
            8'd9:  entry = {8'h55, 8'h81};  // ADC config
            8'd10: entry = {8'h0E, 8'h00};  // back to main map
            8'd11: entry = {8'h01, 8'hC8};  // video selection
            8'd12: entry = {8'h02, 8'h04};  // output control
            8'd13: entry = {8'h03, 8'h0C};  // output format
            8'd14: entry = {8'h1D, 8'h47};  // LLC clock enable
            8'd15: entry = {8'h0B, 8'h00};  // hue
            default: entry = 16'h0000;
        endcase
    end

    assign rom_reg = entry[15:8];
    assign rom_val = entry[7:0];

endmodule

// File: rtl/adv7180_init_seq.sv
// adv7180_init_seq
//   Drives the Wishbone slave port of the I2C master core to load the
//   ADV7180 power-up table: prescaler, core enable, then one 3-byte write
//   (device, register, value) per table entry, polling SR after each byte.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     restart           pulse; reruns the sequence from DONE/ERROR
//     wb_*              Wishbone master to the I2C core
//     busy/done/error   status; err_index = failing entry when error=1
//   Build option: define ADV7180_RETRY_EN to retry a NACK/AL-failed entry
//   up to 3 times before raising error. Timeouts are never retried.
module adv7180_init_seq #(
    parameter logic [7:0]  DEV_ADDR     = 8'h40,
    parameter logic [15:0] PRESCALE     = 16'd99,
    parameter logic [19:0] STARTUP_WAIT = 20'd500000,
    parameter logic [15:0] POLL_LIMIT   = 16'd4000,
    parameter logic [7:0]  TBL_LEN      = 8'd16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    input  logic       wb_ack_i,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] err_index
);
    import adv7180_cfg_pkg::*;

`ifdef ADV7180_RETRY_EN
    localparam logic [1:0] RETRY_MAX = 2'd3;
`else
    localparam logic [1:0] RETRY_MAX = 2'd0;
`endif

    state_t      state, state_d;
    phase_t      phase, phase_d;
    logic [7:0]  index, index_d;
    logic [1:0]  retry, retry_d;
    logic [19:0] wait_cnt, wait_d;
    logic [15:0] poll_cnt, poll_d;
    logic [7:0]  err_index_d;
    logic        cyc_d, we_d;
    logic [2:0]  adr_d;
    logic [7:0]  dat_d;

    // Access request from the current state
    logic        acc_en, acc_we, acc_ack;
    logic [2:0]  acc_adr;
    logic [7:0]  acc_dat;

    logic [7:0]  rom_reg, rom_val;
    logic        unused_sr;

    assign unused_sr = ^{wb_dat_i[6], wb_dat_i[4:2], wb_dat_i[0]};
    assign wb_stb_o  = wb_cyc_o;

    adv7180_init_rom u_rom (
        .index   (index),
        .rom_reg (rom_reg),
        .rom_val (rom_val)
    );

    always_comb begin
        state_d     = state;
        phase_d     = phase;
        index_d     = index;
        retry_d     = retry;
        wait_d      = wait_cnt;
        poll_d      = poll_cnt;
        err_index_d = err_index;
        acc_en      = 1'b0;
        acc_we      = 1'b1;
        acc_adr     = '0;
        acc_dat     = '0;
        acc_ack     = wb_cyc_o & wb_ack_i;

        case (state)
            S_WAIT_PWR: begin
                wait_d = wait_cnt + 20'd1;
                if ({1'b0, wait_cnt} + 21'd1 >= {1'b0, STARTUP_WAIT}) begin
                    wait_d  = '0;
                    state_d = S_PRE_LO;
                end
            end
            S_PRE_LO: begin
                acc_en = 1'b1; acc_adr = REG_PRER_LO; acc_dat = PRESCALE[7:0];
                if (acc_ack) state_d = S_PRE_HI;
            end
            S_PRE_HI: begin
                acc_en = 1'b1; acc_adr = REG_PRER_HI; acc_dat = PRESCALE[15:8];
                if (acc_ack) state_d = S_CTR_EN;
            end
            S_CTR_EN: begin
                acc_en = 1'b1; acc_adr = REG_CTR; acc_dat = CTR_EN;
                if (acc_ack) begin
                    index_d = '0;
                    retry_d = '0;
                    state_d = (TBL_LEN == 8'd0) ? S_DONE : S_LD_DEV;
                end
            end
            S_LD_DEV: begin
                acc_en = 1'b1; acc_adr = REG_TXR; acc_dat = DEV_ADDR;
                if (acc_ack) begin phase_d = PH_DEV; state_d = S_CMD; end
            end
            S_LD_REG: begin
                acc_en = 1'b1; acc_adr = REG_TXR; acc_dat = rom_reg;
                if (acc_ack) begin phase_d = PH_REG; state_d = S_CMD; end
            end
            S_LD_DAT: begin
                acc_en = 1'b1; acc_adr = REG_TXR; acc_dat = rom_val;
                if (acc_ack) begin phase_d = PH_DAT; state_d = S_CMD; end
            end
            S_CMD: begin
                acc_en  = 1'b1;
                acc_adr = REG_CR;
                case (phase)
                    PH_DEV:  acc_dat = CR_STA | CR_WR;
                    PH_REG:  acc_dat = CR_WR;
                    default: acc_dat = CR_STO | CR_WR;
                endcase
                if (acc_ack) begin poll_d = '0; state_d = S_POLL; end
            end
            S_POLL: begin
                acc_en = 1'b1; acc_we = 1'b0; acc_adr = REG_SR;
                if (acc_ack) begin
                    poll_d = poll_cnt + 16'd1;
                    if (wb_dat_i[SR_TIP]) begin
                        // Stuck transfer: abandon without touching the bus
                        if (poll_cnt + 16'd1 >= POLL_LIMIT) begin
                            err_index_d = index;
                            state_d     = S_ERROR;
                        end
                    end else if (wb_dat_i[SR_AL] || wb_dat_i[SR_RXACK]) begin
                        if (retry < RETRY_MAX) begin
                            retry_d = retry + 2'd1;
                            state_d = S_LD_DEV;
                        end else begin
                            state_d = S_FAIL;
                        end
                    end else begin
                        case (phase)
                            PH_DEV:  state_d = S_LD_REG;
                            PH_REG:  state_d = S_LD_DAT;
                            default: state_d = S_NEXT;
                        endcase
                    end
                end
            end
            S_NEXT: begin
                index_d = index + 8'd1;
                retry_d = '0;
                state_d = (index + 8'd1 == TBL_LEN) ? S_DONE : S_LD_DEV;
            end
            S_FAIL: begin
                // STOP to release the bus before reporting
                acc_en = 1'b1; acc_adr = REG_CR; acc_dat = CR_STO;
                if (acc_ack) begin err_index_d = index; state_d = S_ERROR; end
            end
            S_DONE, S_ERROR: begin
                if (restart) begin
                    index_d     = '0;
                    retry_d     = '0;
                    err_index_d = '0;
                    state_d     = S_PRE_LO;
                end
            end
            default: state_d = S_WAIT_PWR;
        endcase

        // Shared Wishbone handshake: launch when idle, hold until ack,
        // drop everything on ack (guarantees an idle cycle between accesses)
        cyc_d = wb_cyc_o;
        adr_d = wb_adr_o;
        dat_d = wb_dat_o;
        we_d  = wb_we_o;
        if (acc_en) begin
            if (!wb_cyc_o) begin
                cyc_d = 1'b1; adr_d = acc_adr; dat_d = acc_dat; we_d = acc_we;
            end else if (wb_ack_i) begin
                cyc_d = 1'b0; adr_d = '0; dat_d = '0; we_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_WAIT_PWR;
            phase     <= PH_DEV;
            index     <= '0;
            retry     <= '0;
            wait_cnt  <= '0;
            poll_cnt  <= '0;
            wb_cyc_o  <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_we_o   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_index <= '0;
        end else begin
            state     <= state_d;
            phase     <= phase_d;
            index     <= index_d;
            retry     <= retry_d;
            wait_cnt  <= wait_d;
            poll_cnt  <= poll_d;
            wb_cyc_o  <= cyc_d;
            wb_adr_o  <= adr_d;
            wb_dat_o  <= dat_d;
            wb_we_o   <= we_d;
            busy      <= (state_d != S_DONE) && (state_d != S_ERROR);
            done      <= (state_d == S_DONE);
            error     <= (state_d == S_ERROR);
            err_index <= err_index_d;
        end
    end

endmodule

// File: tb/tb_adv7180_init_seq.sv
// tb_adv7180_init_seq
//   Scoreboard bench: expected Wishbone writes are queued as each scenario
//   is set up; a model of the I2C core slave records every access, and the
//   stimulus thread drains those records against the expected queue.
module tb_adv7180_init_seq;

`ifdef ADV7180_RETRY_EN
    localparam int RETRIES = 3;
`else
    localparam int RETRIES = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       restart = 1'b0;
    logic [2:0] wb_adr_o;
    logic [7:0] wb_dat_o, wb_dat_i;
    logic       wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;
    logic       busy, done, error;
    logic [7:0] err_index;

    always #5 clk = ~clk;

    adv7180_init_seq #(.STARTUP_WAIT(20'd10)) dut (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_we_o   (wb_we_o),
        .wb_stb_o  (wb_stb_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_ack_i  (wb_ack_i),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_index (err_index)
    );

    logic [7:0] t_reg [16] = '{8'h0F, 8'h00, 8'h04, 8'h17, 8'h31, 8'h3D, 8'h3E, 8'h3F,
                               8'h0E, 8'h55, 8'h0E, 8'h01, 8'h02, 8'h03, 8'h1D, 8'h0B};
    logic [7:0] t_val [16] = '{8'h00, 8'h04, 8'h57, 8'h41, 8'h02, 8'hA2, 8'h6A, 8'hA0,
                               8'h80, 8'h81, 8'h00, 8'hC8, 8'h04, 8'h0C, 8'h47, 8'h00};

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q [$];
    logic [11:0] obs_q [$];   // {we, adr, dat}
    int          sr_reads;

    // Slave model controls (written only by the stimulus thread)
    bit          tip_stuck = 1'b0;
    int          nack_total = 0;
    logic [7:0]  nack_txr = 8'h00;
    logic [7:0]  nack_cr = 8'h00;

    // Slave model state
    int          tip_left;
    int          nack_used;
    bit          pend_nack;
    logic [7:0]  last_txr;

    always @(posedge clk) begin
        if (rst) begin
            wb_ack_i  <= 1'b0;
            wb_dat_i  <= 8'h00;
            tip_left  = 0;
            nack_used = 0;
            pend_nack = 1'b0;
            last_txr  = 8'h00;
        end else if (wb_ack_i) begin
            wb_ack_i <= 1'b0;
        end else if (wb_cyc_o && wb_stb_o) begin
            wb_ack_i <= 1'b1;
            obs_q.push_back({wb_we_o, wb_adr_o, wb_dat_o});
            if (wb_we_o) begin
                if (wb_adr_o == 3'd3) last_txr = wb_dat_o;
                if (wb_adr_o == 3'd4 && wb_dat_o[4]) begin
                    tip_left  = 3;
                    pend_nack = (nack_used < nack_total) && (wb_dat_o == nack_cr) &&
                                (last_txr == nack_txr);
                    if (pend_nack) nack_used++;
                end
            end else if (tip_stuck || tip_left > 0) begin
                wb_dat_i <= 8'h02;
                if (tip_left > 0) tip_left--;
            end else begin
                wb_dat_i <= pend_nack ? 8'h80 : 8'h00;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drain();
        logic [11:0] o;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (o[11]) begin
                if (exp_q.size() == 0) check("wr_unexpected", {21'b0, o[10:0]}, 32'hFFFF_FFFF);
                else                   check("wr", {21'b0, o[10:0]}, exp_q.pop_front());
            end else begin
                check("rd_adr", {29'b0, o[10:8]}, 32'd4);
                sr_reads++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        drain();
    endtask

    task automatic push(input logic [2:0] adr, input logic [7:0] dat);
        exp_q.push_back({21'b0, adr, dat});
    endtask

    task automatic push_init();
        push(3'd0, 8'd99); push(3'd1, 8'd0); push(3'd2, 8'h80);
    endtask

    // Device and register bytes of one entry, as far as a NACK on the reg byte
    task automatic push_head(input int i);
        push(3'd3, 8'h40); push(3'd4, 8'h90); push(3'd3, t_reg[i]); push(3'd4, 8'h10);
    endtask

    task automatic push_entry(input int i);
        push_head(i); push(3'd3, t_val[i]); push(3'd4, 8'h50);
    endtask

    task automatic push_all();
        push_init();
        for (int i = 0; i < 16; i++) push_entry(i);
    endtask

    task automatic hold_reset();
        rst = 1'b1;
        tick(); tick();
        exp_q.delete();
        sr_reads = 0;
    endtask

    // Release reset and check the power-up quiet period before PRE_LO
    task automatic release_reset();
        int n;
        rst = 1'b0;
        tick();
        n = 1;
        check("busy_after_release", {31'b0, busy}, 32'd1);
        while (!wb_cyc_o && n < 100) begin tick(); n++; end
        check("pwr_wait", n, 32'd11);
    endtask

    task automatic wait_end(input int budget);
        int i;
        i = 0;
        while (!(done || error) && i < budget) begin tick(); i++; end
        check("end_in_budget", {31'b0, done | error}, 32'd1);
        tick();
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic [7:0] idx);
        check({tag, "_done"}, {31'b0, done}, {31'b0, d});
        check({tag, "_error"}, {31'b0, error}, {31'b0, e});
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        if (e) check({tag, "_err_index"}, {24'b0, err_index}, {24'b0, idx});
        check({tag, "_q_left"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        int n;
        bit hit;

        // Reset state
        hold_reset();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_error", {31'b0, error}, 32'd0);
        check("rst_cyc_stb", {30'b0, wb_cyc_o, wb_stb_o}, 32'd0);
        check("rst_err_index", {24'b0, err_index}, 32'd0);

        // Full table, clean run
        push_all();
        release_reset();
        wait_end(5000);
        check_status("run", 1'b1, 1'b0, 8'd0);

        // Restart from DONE, plus a restart pulse mid-run that must be ignored
        push_all();
        restart = 1'b1; tick(); restart = 1'b0;
        check("restart_done_clr", {31'b0, done}, 32'd0);
        check("restart_busy", {31'b0, busy}, 32'd1);
        tick();
        check("restart_pre_lo", {28'b0, wb_cyc_o, wb_adr_o}, 32'h8);
        for (int i = 0; i < 200; i++) tick();
        restart = 1'b1; tick(); restart = 1'b0;
        wait_end(5000);
        check_status("restart", 1'b1, 1'b0, 8'd0);

        // NACK on the register byte of entry 5
        hold_reset();
        nack_txr = 8'h3D; nack_cr = 8'h10; nack_total = RETRIES + 1;
        push_init();
        for (int i = 0; i < 5; i++) push_entry(i);
        for (int k = 0; k < RETRIES + 1; k++) push_head(5);
        push(3'd4, 8'h40);
        release_reset();
        wait_end(5000);
        check_status("nack", 1'b0, 1'b1, 8'd5);

`ifdef ADV7180_RETRY_EN
        // Two NACKs on entry 2 are absorbed by retries
        hold_reset();
        nack_txr = 8'h04; nack_cr = 8'h10; nack_total = 2;
        push_init();
        push_entry(0); push_entry(1);
        push_head(2); push_head(2);
        for (int i = 2; i < 16; i++) push_entry(i);
        release_reset();
        wait_end(6000);
        check_status("retry", 1'b1, 1'b0, 8'd0);
`endif
        nack_total = 0;

        // TIP never clears: timeout after POLL_LIMIT reads, no STO write
        hold_reset();
        tip_stuck = 1'b1;
        push_init();
        push(3'd3, 8'h40); push(3'd4, 8'h90);
        release_reset();
        wait_end(20000);
        check_status("timeout", 1'b0, 1'b1, 8'd0);
        check("timeout_sr_reads", sr_reads, 32'd4000);
        n = 0;
        for (int i = 0; i < 50; i++) begin tick(); if (wb_cyc_o) n++; end
        check("timeout_quiet", n, 32'd0);
        tip_stuck = 1'b0;

        // Reset pulse while the register byte of entry 3 is on the bus
        hold_reset();
        push_all();
        release_reset();
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            if (wb_cyc_o && wb_adr_o == 3'd3 && wb_dat_o == 8'h17) hit = 1'b1;
            else tick();
        end
        check("mid_rst_hit", {31'b0, hit}, 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_cyc_stb", {30'b0, wb_cyc_o, wb_stb_o}, 32'd0);
        check("mid_rst_status", {29'b0, busy, done, error}, 32'd0);
        exp_q.delete();
        push_all();
        release_reset();
        wait_end(5000);
        check_status("mid_rst", 1'b1, 1'b0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
